// File: rtl/bp_lce_cmd_burst_buffer.sv
// bp_lce_cmd_burst_buffer
//   Elastic buffer for BedRock LCE command bursts (header + optional data beats).
//   A header FIFO and a data FIFO decouple the network side from the LCE side.
//   Every output, ready included, comes straight from a flop, so there is no
//   combinational path from input to output in either direction.
//   Optional feature macro: BP_LCE_CMD_BUF_PROTOCOL_CHECK_EN (sticky error_o).
module bp_lce_cmd_burst_buffer #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int header_els_p   = 2,
  parameter int data_els_p     = 8,
  parameter int max_beats_p    = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [header_width_p-1:0] in_header_i,
  input  logic                      in_header_v_i,
  output logic                      in_header_ready_and_o,
  input  logic                      in_has_data_i,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic                      in_data_v_i,
  output logic                      in_data_ready_and_o,
  input  logic                      in_last_i,
  output logic [header_width_p-1:0] out_header_o,
  output logic                      out_header_v_o,
  input  logic                      out_header_ready_and_i,
  output logic                      out_has_data_o,
  output logic [data_width_p-1:0]   out_data_o,
  output logic                      out_data_v_o,
  input  logic                      out_data_ready_and_i,
  output logic                      out_last_o,
  output logic                      error_o
);

  localparam int hp_w = (header_els_p > 1) ? $clog2(header_els_p) : 1;
  localparam int dp_w = (data_els_p > 1) ? $clog2(data_els_p) : 1;
  localparam int hc_w = $clog2(header_els_p + 1);
  localparam int dc_w = $clog2(data_els_p + 1);
  localparam int bc_w = $clog2(max_beats_p + 1);

  typedef enum logic {I_HDR = 1'b0, I_DATA = 1'b1} in_state_e;
  typedef enum logic {O_HDR = 1'b0, O_DATA = 1'b1} out_state_e;

  function automatic logic [hp_w-1:0] hptr_inc(input logic [hp_w-1:0] p);
    return (p == hp_w'(header_els_p - 1)) ? '0 : p + hp_w'(1);
  endfunction

  function automatic logic [dp_w-1:0] dptr_inc(input logic [dp_w-1:0] p);
    return (p == dp_w'(data_els_p - 1)) ? '0 : p + dp_w'(1);
  endfunction

  logic [header_width_p:0] hdr_mem_q [header_els_p];
  logic [header_width_p:0] hdr_mem_d [header_els_p];
  logic [data_width_p:0]   dat_mem_q [data_els_p];
  logic [data_width_p:0]   dat_mem_d [data_els_p];
  logic [hp_w-1:0] hdr_wptr_q, hdr_wptr_d, hdr_rptr_q, hdr_rptr_d;
  logic [dp_w-1:0] dat_wptr_q, dat_wptr_d, dat_rptr_q, dat_rptr_d;
  logic [hc_w-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [dc_w-1:0] dat_cnt_q, dat_cnt_d;
  logic [bc_w-1:0] beat_cnt_q, beat_cnt_d;
  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

  logic in_header_ready_q, in_header_ready_d, in_data_ready_q, in_data_ready_d;
  logic out_header_v_q, out_header_v_d, out_data_v_q, out_data_v_d;
  logic out_has_data_q, out_has_data_d, out_last_q, out_last_d;
  logic [header_width_p-1:0] out_header_q, out_header_d;
  logic [data_width_p-1:0]   out_data_q, out_data_d;
  logic hdr_enq, hdr_deq, dat_enq, dat_deq;

  assign hdr_enq = in_header_v_i & in_header_ready_q;
  assign dat_enq = in_data_v_i & in_data_ready_q;
  assign hdr_deq = out_header_v_q & out_header_ready_and_i;
  assign dat_deq = out_data_v_q & out_data_ready_and_i;

  // FIFO storage, pointers and occupancy for both queues.
  always_comb begin
    hdr_mem_d  = hdr_mem_q;
    dat_mem_d  = dat_mem_q;
    hdr_wptr_d = hdr_wptr_q;
    hdr_rptr_d = hdr_rptr_q;
    dat_wptr_d = dat_wptr_q;
    dat_rptr_d = dat_rptr_q;
    if (hdr_enq) begin
      hdr_mem_d[hdr_wptr_q] = {in_has_data_i, in_header_i};
      hdr_wptr_d = hptr_inc(hdr_wptr_q);
    end else begin
      hdr_wptr_d = hdr_wptr_q;
    end
    if (hdr_deq) begin
      hdr_rptr_d = hptr_inc(hdr_rptr_q);
    end else begin
      hdr_rptr_d = hdr_rptr_q;
    end
    if (dat_enq) begin
      dat_mem_d[dat_wptr_q] = {in_last_i, in_data_i};
      dat_wptr_d = dptr_inc(dat_wptr_q);
    end else begin
      dat_wptr_d = dat_wptr_q;
    end
    if (dat_deq) begin
      dat_rptr_d = dptr_inc(dat_rptr_q);
    end else begin
      dat_rptr_d = dat_rptr_q;
    end
    hdr_cnt_d = hdr_cnt_q + hc_w'(hdr_enq) - hc_w'(hdr_deq);
    dat_cnt_d = dat_cnt_q + dc_w'(dat_enq) - dc_w'(dat_deq);
  end

  // Input FSM: accept a header, then its data beats until last.
  always_comb begin
    in_state_d = in_state_q;
    beat_cnt_d = beat_cnt_q;
    case (in_state_q)
      I_HDR: begin
        if (hdr_enq && in_has_data_i) begin
          in_state_d = I_DATA;
          beat_cnt_d = '0;
        end else begin
          in_state_d = I_HDR;
        end
      end
      I_DATA: begin
        if (dat_enq) begin
          // Saturate so an over-long burst cannot wrap the counter.
          beat_cnt_d = (beat_cnt_q == bc_w'(max_beats_p)) ? beat_cnt_q : beat_cnt_q + bc_w'(1);
          in_state_d = in_last_i ? I_HDR : I_DATA;
        end else begin
          in_state_d = I_DATA;
        end
      end
      default: in_state_d = I_HDR;
    endcase
  end

  // Output FSM and next values of every registered output.
  always_comb begin
    out_state_d = out_state_q;
    case (out_state_q)
      O_HDR: begin
        if (hdr_deq && out_has_data_q) out_state_d = O_DATA;
        else                           out_state_d = O_HDR;
      end
      O_DATA: begin
        if (dat_deq && out_last_q) out_state_d = O_HDR;
        else                       out_state_d = O_DATA;
      end
      default: out_state_d = O_HDR;
    endcase
    in_header_ready_d = (in_state_d == I_HDR) && (hdr_cnt_d != hc_w'(header_els_p));
    in_data_ready_d   = (in_state_d == I_DATA) && (dat_cnt_d != dc_w'(data_els_p));
    out_header_v_d    = (out_state_d == O_HDR) && (hdr_cnt_d != '0);
    out_data_v_d      = (out_state_d == O_DATA) && (dat_cnt_d != '0);
    // Reading the next-state memory makes an entry written this edge visible next cycle.
    {out_has_data_d, out_header_d} = hdr_mem_d[hdr_rptr_d];
    {out_last_d, out_data_d}       = dat_mem_d[dat_rptr_d];
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < header_els_p; i++) hdr_mem_q[i] <= '0;
      for (int i = 0; i < data_els_p; i++)   dat_mem_q[i] <= '0;
      hdr_wptr_q        <= '0;
      hdr_rptr_q        <= '0;
      dat_wptr_q        <= '0;
      dat_rptr_q        <= '0;
      hdr_cnt_q         <= '0;
      dat_cnt_q         <= '0;
      beat_cnt_q        <= '0;
      in_state_q        <= I_HDR;
      out_state_q       <= O_HDR;
      in_header_ready_q <= 1'b0;
      in_data_ready_q   <= 1'b0;
      out_header_v_q    <= 1'b0;
      out_data_v_q      <= 1'b0;
      out_has_data_q    <= 1'b0;
      out_last_q        <= 1'b0;
      out_header_q      <= '0;
      out_data_q        <= '0;
    end else begin
      hdr_mem_q         <= hdr_mem_d;
      dat_mem_q         <= dat_mem_d;
      hdr_wptr_q        <= hdr_wptr_d;
      hdr_rptr_q        <= hdr_rptr_d;
      dat_wptr_q        <= dat_wptr_d;
      dat_rptr_q        <= dat_rptr_d;
      hdr_cnt_q         <= hdr_cnt_d;
      dat_cnt_q         <= dat_cnt_d;
      beat_cnt_q        <= beat_cnt_d;
      in_state_q        <= in_state_d;
      out_state_q       <= out_state_d;
      in_header_ready_q <= in_header_ready_d;
      in_data_ready_q   <= in_data_ready_d;
      out_header_v_q    <= out_header_v_d;
      out_data_v_q      <= out_data_v_d;
      out_has_data_q    <= out_has_data_d;
      out_last_q        <= out_last_d;
      out_header_q      <= out_header_d;
      out_data_q        <= out_data_d;
    end
  end

  assign in_header_ready_and_o = in_header_ready_q;
  assign in_data_ready_and_o   = in_data_ready_q;
  assign out_header_v_o        = out_header_v_q;
  assign out_data_v_o          = out_data_v_q;
  assign out_has_data_o        = out_has_data_q;
  assign out_last_o            = out_last_q;
  assign out_header_o          = out_header_q;
  assign out_data_o            = out_data_q;

`ifdef BP_LCE_CMD_BUF_PROTOCOL_CHECK_EN
  logic error_q, error_d;
  logic [dc_w-1:0] dat_free_s;

  assign dat_free_s = dc_w'(data_els_p) - dat_cnt_q;

  // Sticky flag: over-long burst, or a data command accepted without room for a full burst.
  always_comb begin
    error_d = error_q;
    if (dat_enq && !in_last_i && (beat_cnt_q == bc_w'(max_beats_p - 1))) begin
      error_d = 1'b1;
    end else if (hdr_enq && in_has_data_i && (dat_free_s < dc_w'(max_beats_p))) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) error_q <= 1'b0;
    else            error_q <= error_d;
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_lce_cmd_burst_buffer.sv
// Scoreboard bench for bp_lce_cmd_burst_buffer: directed scenarios plus
// randomized bursts; the expected output stream is a queue of header/beat items.
module tb_bp_lce_cmd_burst_buffer;
  localparam int HW = 64, DW = 64, HE = 2, DE = 8, MB = 8;
`ifdef BP_LCE_CMD_BUF_PROTOCOL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [HW-1:0] in_header;
  logic in_header_v, in_header_rdy, in_has_data;
  logic [DW-1:0] in_data;
  logic in_data_v, in_data_rdy, in_last;
  logic [HW-1:0] out_header;
  logic out_header_v, out_header_rdy, out_has_data;
  logic [DW-1:0] out_data;
  logic out_data_v, out_data_rdy, out_last;
  logic error;

  always #5 clk = ~clk;

  bp_lce_cmd_burst_buffer #(.header_width_p(HW), .data_width_p(DW), .header_els_p(HE),
                            .data_els_p(DE), .max_beats_p(MB)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_header_i(in_header), .in_header_v_i(in_header_v), .in_header_ready_and_o(in_header_rdy),
    .in_has_data_i(in_has_data), .in_data_i(in_data), .in_data_v_i(in_data_v),
    .in_data_ready_and_o(in_data_rdy), .in_last_i(in_last),
    .out_header_o(out_header), .out_header_v_o(out_header_v),
    .out_header_ready_and_i(out_header_rdy), .out_has_data_o(out_has_data),
    .out_data_o(out_data), .out_data_v_o(out_data_v),
    .out_data_ready_and_i(out_data_rdy), .out_last_o(out_last), .error_o(error));

  typedef struct packed { logic is_hdr; logic flag; logic [63:0] val; } item_t;
  item_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int rdy_mode = 0;       // 0: both ready, 1: random, 2: header side held off
  int occ = 0;            // beats held in the buffer
  int beat_in = 0;        // beats accepted in the current input burst
  bit err_exp = 1'b0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output-side ready generation.
  initial begin
    out_header_rdy = 1'b0;
    out_data_rdy   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin out_header_rdy = 1'b1; out_data_rdy = 1'b1; end
        1: begin out_header_rdy = 1'($urandom_range(0, 1)); out_data_rdy = 1'($urandom_range(0, 1)); end
        2: begin out_header_rdy = 1'b0; out_data_rdy = 1'b1; end
        default: begin out_header_rdy = 1'b1; out_data_rdy = 1'b1; end
      endcase
    end
  end

  // Monitor: pops the scoreboard on output handshakes and tracks the error model.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        chk("error_o", 66'(error), 66'(err_exp));
        if (out_header_v && out_header_rdy) begin
          if (exp_q.size() == 0) chk("spurious_hdr", 66'(out_header), 66'h3_dead_dead_dead_dead);
          else begin
            it = exp_q.pop_front();
            chk("hdr_item", {1'b1, out_has_data, out_header}, it);
          end
        end
        if (out_data_v && out_data_rdy) begin
          occ--;
          if (exp_q.size() == 0) chk("spurious_beat", 66'(out_data), 66'h3_dead_dead_dead_dead);
          else begin
            it = exp_q.pop_front();
            chk("beat_item", {1'b0, out_last, out_data}, it);
          end
        end
        if (in_header_v && in_header_rdy && in_has_data) begin
          if (CHK_EN && (DE - occ) < MB) err_exp = 1'b1;
          beat_in = 0;
        end
        if (in_data_v && in_data_rdy) begin
          if (CHK_EN && !in_last && beat_in == MB - 1) err_exp = 1'b1;
          beat_in++;
          occ++;
        end
      end
    end
  end

  task automatic xfer_hdr(input logic [63:0] h, input logic hd);
    int t = 0;
    in_header = h; in_has_data = hd; in_header_v = 1'b1;
    @(negedge clk);
    while (!in_header_rdy && t < 300) begin t++; @(negedge clk); end
    if (t >= 300) chk("hdr_accept_timeout", 66'(t), 66'(0));
    else exp_q.push_back({1'b1, hd, h});
    @(posedge clk);
    #1;
    in_header_v = 1'b0;
  endtask

  task automatic xfer_beat(input logic [63:0] d, input logic l);
    int t = 0;
    in_data = d; in_last = l; in_data_v = 1'b1;
    @(negedge clk);
    while (!in_data_rdy && t < 300) begin t++; @(negedge clk); end
    if (t >= 300) chk("beat_accept_timeout", 66'(t), 66'(0));
    else exp_q.push_back({1'b0, l, d});
    @(posedge clk);
    #1;
    in_data_v = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin t++; step(); end
    chk({name, "_drained"}, 66'(exp_q.size()), 66'(0));
    step();
    chk({name, "_idle_v"}, {out_header_v, out_data_v}, 66'(0));
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    in_header_v = 1'b0; in_data_v = 1'b0;
    #1;
    chk("rst_valids", {out_header_v, out_data_v}, 66'(0));
    chk("rst_readys", {in_header_rdy, in_data_rdy}, 66'(0));
    chk("rst_data", {out_header, out_data}, 66'(0));
    chk("rst_err", 66'(error), 66'(0));
    exp_q.delete();
    occ = 0; beat_in = 0; err_exp = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int nb;
    reset_n = 1'b0;
    in_header = '0; in_header_v = 1'b0; in_has_data = 1'b0;
    in_data = '0; in_data_v = 1'b0; in_last = 1'b0;
    #2;
    apply_reset();
    chk("idle_hdr_rdy", 66'(in_header_rdy), 66'(1));
    chk("idle_data_rdy", 66'(in_data_rdy), 66'(0));
    chk("idle_out_v", {out_header_v, out_data_v}, 66'(0));

    // Header-only command.
    xfer_hdr(64'h1, 1'b0);
    chk("ho_hdr", {out_header_v, out_has_data, out_header}, {2'b10, 64'h1});
    chk("ho_data_v", 66'(out_data_v), 66'(0));
    drain("ho");

    // Full-length data command, no stall.
    xfer_hdr(64'h2, 1'b1);
    for (int i = 0; i < 8; i++) xfer_beat(64'hA0 + 64'(i), i == 7);
    drain("burst8");

    // Header backpressure: third header refused while two are held.
    rdy_mode = 2;
    step();
    xfer_hdr(64'h11, 1'b0);
    xfer_hdr(64'h12, 1'b0);
    in_header = 64'h13; in_has_data = 1'b0; in_header_v = 1'b1;
    repeat (3) step();
    chk("bp_refused", 66'(in_header_rdy), 66'(0));
    chk("bp_held_hdr", {out_header_v, out_header}, {2'b01, 64'h11});
    in_header_v = 1'b0;
    rdy_mode = 0;
    xfer_hdr(64'h13, 1'b0);
    drain("bp");

    // Randomized traffic with random backpressure on both sides.
    rdy_mode = 1;
    for (int c = 0; c < 40; c++) begin
      logic hd;
      hd = 1'($urandom_range(0, 1));
      xfer_hdr({32'($urandom), 32'(c)}, hd);
      if (hd) begin
        nb = $urandom_range(1, MB);
        for (int b = 0; b < nb; b++) xfer_beat({32'($urandom), 32'(b)}, b == nb - 1);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    drain("rand");

    // Reset in the middle of a burst.
    rdy_mode = 0;
    xfer_hdr(64'h4, 1'b1);
    for (int i = 0; i < 3; i++) xfer_beat(64'hB0 + 64'(i), 1'b0);
    #1;
    apply_reset();
    chk("post_rst_rdy", {in_header_rdy, in_data_rdy}, 66'(2));
    xfer_hdr(64'h5, 1'b0);
    drain("post_rst");

    // Nine-beat burst exceeds the limit.
    xfer_hdr(64'h6, 1'b1);
    for (int i = 0; i < 9; i++) xfer_beat(64'hC0 + 64'(i), i == 8);
    drain("burst9");
    chk("burst9_err", 66'(error), 66'(CHK_EN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
